// File: rtl/eth_decap.sv
// eth_decap: checks and strips the 16-byte encapsulation header from 10G MAC RX frames and
// steers the payload beats by tag into FIFO0/FIFO1. Define ETH_DECAP_MAC_FILTER_EN to filter on destination MAC.
module eth_decap #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    output logic        fifo0_wr_en,
    output logic [73:0] fifo0_din,
    input  logic        fifo0_full,
    input  logic        fifo0_prog_full,
    output logic        fifo1_wr_en,
    output logic [73:0] fifo1_din,
    input  logic        fifo1_full,
    input  logic        fifo1_prog_full,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_drops,
    output logic        stat_overflow
);
    localparam int unsigned BW = $clog2(MAX_BEATS) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DROP} state_t;

    state_t        state;
    logic          dst_ok;
    logic          sel;
    logic [BW-1:0] beats;

    logic          dst_match;
`ifdef ETH_DECAP_MAC_FILTER_EN
    logic [47:0]   dst;
    always_comb begin
        dst = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],  s_axis_rx_tdata[23:16],
               s_axis_rx_tdata[31:24], s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
        dst_match = (dst == LOCAL_MAC) || (dst == '1);
    end
`else
    logic          unused_local_mac;
    always_comb begin
        dst_match = 1'b1;
        unused_local_mac = ^LOCAL_MAC;
    end
`endif

    logic [15:0] ethertype;
    logic [7:0]  tag;
    logic        tag_pf;
    logic        accept;
    logic        sel_full;
    logic        cap;
    logic        w_last;
    logic        w_err;
    logic [73:0] word;

    always_comb begin
        ethertype = {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
        tag       = s_axis_rx_tdata[55:48];
        tag_pf    = tag[0] ? fifo1_prog_full : fifo0_prog_full;
        accept    = (ethertype == ETHERTYPE) && (tag[7:1] == '0) && dst_ok && !tag_pf;
        sel_full  = sel ? fifo1_full : fifo0_full;
        // An over-long frame is cut at its MAX_BEATS-th beat, which is marked last and bad.
        cap       = !s_axis_rx_tlast && (beats == LAST_BEAT);
        w_last    = s_axis_rx_tlast | cap;
        w_err     = (s_axis_rx_tlast & ~s_axis_rx_tuser) | cap;
        word      = {w_err, w_last, s_axis_rx_tkeep, s_axis_rx_tdata};
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            dst_ok        <= 1'b0;
            sel           <= 1'b0;
            beats         <= '0;
            fifo0_wr_en   <= 1'b0;
            fifo0_din     <= '0;
            fifo1_wr_en   <= 1'b0;
            fifo1_din     <= '0;
            stat_frames   <= '0;
            stat_drops    <= '0;
            stat_overflow <= 1'b0;
        end else begin
            fifo0_wr_en <= 1'b0;
            fifo1_wr_en <= 1'b0;
            if (s_axis_rx_tvalid) begin
                unique case (state)
                    IDLE: begin
                        if (s_axis_rx_tlast) begin
                            stat_drops <= stat_drops + 1'b1;
                        end else begin
                            dst_ok <= dst_match;
                            state  <= HDR1;
                        end
                    end
                    HDR1: begin
                        if (s_axis_rx_tlast) begin
                            stat_drops <= stat_drops + 1'b1;
                            state      <= IDLE;
                        end else if (accept) begin
                            sel   <= tag[0];
                            beats <= '0;
                            state <= PAYLOAD;
                        end else begin
                            stat_drops <= stat_drops + 1'b1;
                            state      <= DROP;
                        end
                    end
                    PAYLOAD: begin
                        beats <= beats + 1'b1;
                        if (sel_full) begin
                            stat_overflow <= 1'b1;
                        end else if (sel) begin
                            fifo1_wr_en <= 1'b1;
                            fifo1_din   <= word;
                        end else begin
                            fifo0_wr_en <= 1'b1;
                            fifo0_din   <= word;
                        end
                        if (s_axis_rx_tlast) begin
                            state <= IDLE;
                            if (w_err) stat_drops  <= stat_drops + 1'b1;
                            else       stat_frames <= stat_frames + 1'b1;
                        end else if (cap) begin
                            stat_drops <= stat_drops + 1'b1;
                            state      <= DROP;
                        end
                    end
                    DROP: begin
                        if (s_axis_rx_tlast) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
